// File: rtl/frame_sequencer.sv
// Frame-rate scheduler for the LED pipeline: periodic frame tick, animator/driver start pulses,
// ping-pong bank ownership, frame and dropped-frame counters.
module frame_sequencer #(
    parameter int unsigned c_frame_div = 100000,
    parameter int unsigned c_div_w     = $clog2(c_frame_div),
    parameter int unsigned c_cnt_w     = 16,
    parameter int unsigned c_ovf_w     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    output logic               o_anim_drq,
    input  logic               i_anim_done,
    output logic               o_drv_start,
    input  logic               i_drv_done,
    output logic               o_bank,
    output logic               o_busy,
    output logic [c_cnt_w-1:0] o_frame_cnt,
    output logic [c_ovf_w-1:0] o_overrun_cnt
);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_frame_div - 1);

    typedef enum logic {
        s_idle = 1'b0,
        s_run  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               state_d;
    logic [c_div_w-1:0]   r_div;
    logic                 r_anim_ok;
    logic                 r_drv_ok;
    logic                 anim_ok_d;
    logic                 drv_ok_d;
    logic                 anim_drq_d;
    logic                 drv_start_d;
    logic                 bank_d;
    logic [c_cnt_w-1:0]   frame_cnt_d;
    logic [c_ovf_w-1:0]   overrun_cnt_d;
    logic                 tick_c;

    // Frame timer: free-runs while enabled, held at zero otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (!i_enable) begin
            r_div <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    assign tick_c = i_enable && (r_div == c_div_last);

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= s_idle;
            r_anim_ok     <= 1'b0;
            r_drv_ok      <= 1'b0;
            o_anim_drq    <= 1'b0;
            o_drv_start   <= 1'b0;
            o_bank        <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_cnt   <= '0;
            o_overrun_cnt <= '0;
        end else begin
            r_state       <= state_d;
            r_anim_ok     <= anim_ok_d;
            r_drv_ok      <= drv_ok_d;
            o_anim_drq    <= anim_drq_d;
            o_drv_start   <= drv_start_d;
            o_bank        <= bank_d;
            o_busy        <= (state_d == s_run);
            o_frame_cnt   <= frame_cnt_d;
            o_overrun_cnt <= overrun_cnt_d;
        end
    end

    // Next-state logic; a tick while a frame is still in flight is dropped and counted
    always_comb begin
        state_d       = r_state;
        anim_ok_d     = r_anim_ok;
        drv_ok_d      = r_drv_ok;
        anim_drq_d    = 1'b0;
        drv_start_d   = 1'b0;
        bank_d        = o_bank;
        frame_cnt_d   = o_frame_cnt;
        overrun_cnt_d = o_overrun_cnt;

        case (r_state)
            s_idle: begin
                if (tick_c) begin
                    state_d     = s_run;
                    bank_d      = ~o_bank;
                    anim_drq_d  = 1'b1;
                    drv_start_d = 1'b1;
                    frame_cnt_d = o_frame_cnt + c_cnt_w'(1);
                    anim_ok_d   = 1'b0;
                    drv_ok_d    = 1'b0;
                end
            end
            s_run: begin
                anim_ok_d = r_anim_ok | i_anim_done;
                drv_ok_d  = r_drv_ok | i_drv_done;
                if (anim_ok_d && drv_ok_d) begin
                    state_d = s_idle;
                end
                if (tick_c && (o_overrun_cnt != '1)) begin
                    overrun_cnt_d = o_overrun_cnt + c_ovf_w'(1);
                end
            end
            default: state_d = s_idle;
        endcase
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a short frame period (8 cycles).
module tb_frame_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic        o_anim_drq;
    logic        i_anim_done;
    logic        o_drv_start;
    logic        i_drv_done;
    logic        o_bank;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic [7:0]  o_overrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frame_sequencer #(.c_frame_div(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .o_anim_drq   (o_anim_drq),
        .i_anim_done  (i_anim_done),
        .o_drv_start  (o_drv_start),
        .i_drv_done   (i_drv_done),
        .o_bank       (o_bank),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .o_overrun_cnt(o_overrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Advance one cycle; done inputs are single-cycle pulses by default
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        i_anim_done = 1'b0;
        i_drv_done  = 1'b0;
    endtask

    // Reset, release just after an edge; the caller's current cycle becomes cycle 0
    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_enable    = 1'b0;
        i_anim_done = 1'b0;
        i_drv_done  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        do_reset();
        i_enable = 1'b1;
        while (cyc < 9) step();
        checks++;
        if (o_busy !== 1'b1 || o_bank !== 1'b1 || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_pre busy=%b bank=%b cnt=%0d want 1 1 1", o_busy, o_bank, o_frame_cnt);
        end
        #2;
        i_enable    = 1'($urandom_range(1));
        i_anim_done = 1'($urandom_range(1));
        i_drv_done  = 1'($urandom_range(1));
        i_rst_n     = 1'b0;
        #1;
        checks++;
        if ({o_anim_drq, o_drv_start, o_bank, o_busy, o_frame_cnt, o_overrun_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_async outs=%h want 0", {o_anim_drq, o_drv_start, o_bank, o_busy, o_frame_cnt, o_overrun_cnt});
        end
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_anim_drq, o_drv_start, o_bank, o_busy, o_frame_cnt, o_overrun_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_held outs=%h want 0", {o_anim_drq, o_drv_start, o_bank, o_busy, o_frame_cnt, o_overrun_cnt});
        end
    endtask

    task automatic test_periodic();
        int pc[3];
        int pb[3];
        int pf[3];
        int n = 0;
        int done_at = -1;
        int split = 0;
        do_reset();
        i_enable = 1'b1;
        while (cyc < 27) begin
            step();
            if (o_anim_drq !== o_drv_start) split++;
            if (o_anim_drq === 1'b1) begin
                if (n < 3) begin
                    pc[n] = cyc;
                    pb[n] = int'(o_bank);
                    pf[n] = int'(o_frame_cnt);
                end
                n++;
                done_at = cyc + 3;
            end
            if (cyc == done_at) begin
                i_anim_done = 1'b1;
                i_drv_done  = 1'b1;
            end
        end
        checks++;
        if (n !== 3 || split !== 0) begin
            errors++;
            $display("FAIL periodic_count pulses=%0d split=%0d want 3 0", n, split);
        end
        if (n >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pc[i] !== 8 * (i + 1) || pb[i] !== ((i + 1) % 2) || pf[i] !== i + 1) begin
                    errors++;
                    $display("FAIL periodic_frame%0d cyc=%0d bank=%0d cnt=%0d want %0d %0d %0d",
                             i, pc[i], pb[i], pf[i], 8 * (i + 1), (i + 1) % 2, i + 1);
                end
            end
        end
        checks++;
        if (o_overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL periodic_ovf got=%0d want 0", o_overrun_cnt);
        end
    endtask

    task automatic test_overrun();
        int first = -1;
        int second = -1;
        int bank_flip = 0;
        int busy20 = -1;
        int busy21 = -1;
        do_reset();
        i_enable = 1'b1;
        while (cyc < 26) begin
            step();
            if (o_anim_drq === 1'b1) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            if (cyc > 8 && cyc < 24 && o_bank !== 1'b1) bank_flip++;
            if (cyc == 20) busy20 = int'(o_busy);
            if (cyc == 21) busy21 = int'(o_busy);
            if (cyc == 11) i_anim_done = 1'b1;
            if (cyc == 20) i_drv_done = 1'b1;
        end
        checks++;
        if (first !== 8 || second !== 24) begin
            errors++;
            $display("FAIL overrun_pulses first=%0d second=%0d want 8 24", first, second);
        end
        checks++;
        if (o_overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL overrun_cnt got=%0d want 1", o_overrun_cnt);
        end
        checks++;
        if (bank_flip !== 0 || o_bank !== 1'b0 || o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overrun_bank flips=%0d bank=%b cnt=%0d want 0 0 2", bank_flip, o_bank, o_frame_cnt);
        end
        checks++;
        if (busy20 !== 1 || busy21 !== 0) begin
            errors++;
            $display("FAIL overrun_busy c20=%0d c21=%0d want 1 0", busy20, busy21);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        i_enable = 1'b1;
        while (cyc < 2402) begin
            step();
            if (cyc == 100) begin
                checks++;
                if (o_overrun_cnt !== 8'd11) begin
                    errors++;
                    $display("FAIL sat_mid got=%0d want 11", o_overrun_cnt);
                end
            end
            if (cyc == 2047) begin
                checks++;
                if (o_overrun_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_before got=%0d want 254", o_overrun_cnt);
                end
            end
        end
        checks++;
        if (o_overrun_cnt !== 8'd255 || o_frame_cnt !== 16'd1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_end ovf=%0d cnt=%0d busy=%b want 255 1 1", o_overrun_cnt, o_frame_cnt, o_busy);
        end
    endtask

    task automatic test_done_on_tick();
        int early = 0;
        int next_at = -1;
        do_reset();
        i_enable = 1'b1;
        while (cyc < 26) begin
            step();
            if (o_anim_drq === 1'b1 && cyc > 8) begin
                if (next_at < 0) next_at = cyc;
                if (cyc < 24) early++;
            end
            if (cyc == 15) begin
                i_anim_done = 1'b1;
                i_drv_done  = 1'b1;
            end
            if (cyc == 16) begin
                checks++;
                if (o_overrun_cnt !== 8'd1 || o_busy !== 1'b0 || o_anim_drq !== 1'b0) begin
                    errors++;
                    $display("FAIL tickdone_drop ovf=%0d busy=%b drq=%b want 1 0 0", o_overrun_cnt, o_busy, o_anim_drq);
                end
            end
        end
        checks++;
        if (next_at !== 24 || early !== 0 || o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL tickdone_next at=%0d early=%0d cnt=%0d want 24 0 2", next_at, early, o_frame_cnt);
        end
    endtask

    task automatic test_disable_mid_run();
        int stray = 0;
        int en_cyc;
        int got = -1;
        do_reset();
        i_enable = 1'b1;
        while (cyc < 12) begin
            step();
            if (cyc == 9) i_enable = 1'b0;
            if (cyc == 11) begin
                i_anim_done = 1'b1;
                i_drv_done  = 1'b1;
            end
        end
        checks++;
        if (o_busy !== 1'b0 || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL disable_finish busy=%b cnt=%0d want 0 1", o_busy, o_frame_cnt);
        end
        while (cyc < 40) begin
            step();
            if (o_anim_drq !== 1'b0 || o_drv_start !== 1'b0 || o_busy !== 1'b0) stray++;
            if (cyc == 15) i_anim_done = 1'b1;
            if (cyc == 20) i_drv_done = 1'b1;
            if (cyc == 25) begin
                i_anim_done = 1'b1;
                i_drv_done  = 1'b1;
            end
        end
        checks++;
        if (stray !== 0 || o_frame_cnt !== 16'd1 || o_overrun_cnt !== 8'd0 || o_bank !== 1'b1) begin
            errors++;
            $display("FAIL disable_idle stray=%0d cnt=%0d ovf=%0d bank=%b want 0 1 0 1", stray, o_frame_cnt, o_overrun_cnt, o_bank);
        end
        i_enable = 1'b1;
        en_cyc   = cyc;
        for (int i = 0; i < 30 && got < 0; i++) begin
            step();
            if (o_anim_drq === 1'b1) got = cyc - en_cyc;
        end
        checks++;
        if (got !== 8 || o_bank !== 1'b0 || o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL reenable_latency got=%0d bank=%b cnt=%0d want 8 0 2 (-1 = no pulse)", got, o_bank, o_frame_cnt);
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_enable    = 1'b0;
        i_anim_done = 1'b0;
        i_drv_done  = 1'b0;
        test_reset();
        test_periodic();
        test_overrun();
        test_saturate();
        test_done_on_tick();
        test_disable_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
